alu_divider: RTL and testbench

Iterative 32-bit integer divider for MIPS DIV/DIVU in the EX stage. Produces quotient (LO) and remainder (HI) one bit per cycle using restoring division on operand magnitudes. Drives the EX_ALU_Stall input of the hazard controller so the divide instruction is held in EX until its result is ready. Consumes the pipeline's M_Stall so a finished result is held, and not recomputed, while downstream stages are stalled.

---
 rtl/alu_divider.sv | 115 +++++++++++
 tb/tb_alu_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, with sign correction applied on the final iteration.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             M_Stall,
    input  logic             Flush,
    output logic             EX_ALU_Stall,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Valid
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dq_reg, dq_next;          // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             q_neg_reg, q_neg_next;
    logic             r_neg_reg, r_neg_next;
    logic [WIDTH-1:0] quotient_next, remainder_next;

    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    // Partial remainder is always below the divisor, so the trial difference fits in WIDTH bits.
    assign shifted  = {rem_reg, dq_reg[WIDTH-1]};
    assign q_bit    = (shifted >= {1'b0, divisor_reg});
    assign rem_step = q_bit ? (shifted[WIDTH-1:0] - divisor_reg) : shifted[WIDTH-1:0];
    assign quo_step = {dq_reg[WIDTH-2:0], q_bit};

    assign dvd_mag = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    assign dvs_mag = (Signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;

    assign Valid        = (state_reg == DONE);
    assign EX_ALU_Stall = ~Flush & (((state_reg == IDLE) & Start) | (state_reg == BUSY));

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        dq_next        = dq_reg;
        divisor_next   = divisor_reg;
        rem_next       = rem_reg;
        q_neg_next     = q_neg_reg;
        r_neg_next     = r_neg_reg;
        quotient_next  = Quotient;
        remainder_next = Remainder;

        case (state_reg)
            IDLE: begin
                if (Start && !Flush) begin
                    dq_next      = dvd_mag;
                    divisor_next = dvs_mag;
                    rem_next     = '0;
                    q_neg_next   = Signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                    r_neg_next   = Signed & Dividend[WIDTH-1];
                    count_next   = CW'(WIDTH);
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                dq_next    = quo_step;
                rem_next   = rem_step;
                count_next = count_reg - 1'b1;
                if (count_reg == CW'(1)) begin
                    quotient_next  = q_neg_reg ? -quo_step : quo_step;
                    remainder_next = r_neg_reg ? -rem_step : rem_step;
                    state_next     = DONE;
                end
            end
            DONE: begin
                // Held while downstream is stalled; Start is ignored here so no restart.
                if (!M_Stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (Flush) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            dq_reg      <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            dq_reg      <= dq_next;
            divisor_reg <= divisor_next;
            rem_reg     <= rem_next;
            q_neg_reg   <= q_neg_next;
            r_neg_reg   <= r_neg_next;
            Quotient    <= quotient_next;
            Remainder   <= remainder_next;
        end
    end
endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: scoreboard of expected quotient/remainder,
// latency and stall-length checks, M_Stall hold, flush and async reset scenarios.
module tb_alu_divider;
    logic        clk;
    logic        rst_n;
    logic        Start, Signed, M_Stall, Flush;
    logic [31:0] Dividend, Divisor;
    logic        EX_ALU_Stall, Valid;
    logic [31:0] Quotient, Remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    alu_divider #(.WIDTH(32)) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .Start       (Start),
        .Signed      (Signed),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .M_Stall     (M_Stall),
        .Flush       (Flush),
        .EX_ALU_Stall(EX_ALU_Stall),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Valid       (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (!sgn) begin
            if (b == 32'd0) begin
                e.q = 32'hFFFF_FFFF;
                e.r = a;
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end else if (b == 32'd0) begin
            e.q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
            e.r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.q = 32'($signed(a) / $signed(b));
            e.r = 32'($signed(a) % $signed(b));
        end
        return e;
    endfunction

    // Issues one divide with Start held, checks latency, stall length and result,
    // then holds DONE for mst cycles via M_Stall before letting the op leave EX.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int mst, input string tag);
        exp_t e;
        int   cyc;
        int   stalls;
        bit   got;
        sb.push_back(model(sgn, a, b));
        @(negedge clk);
        Start = 1'b1; Signed = sgn; Dividend = a; Divisor = b; M_Stall = (mst > 0);
        cyc = 0; stalls = 0; got = 0;
        while (!got && cyc < 100) begin
            #1;
            if (Valid) got = 1;
            else begin
                if (EX_ALU_Stall) stalls++;
                @(negedge clk);
                cyc++;
                if (cyc == 3) begin
                    Dividend = $urandom; Divisor = $urandom; Signed = ~sgn;
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: Valid never rose within %0d cycles, want 33", tag, cyc);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checks++;
            if (cyc !== 33) begin
                errors++; $display("FAIL %s latency got %0d want 33", tag, cyc);
            end
            checks++;
            if (stalls !== 33) begin
                errors++; $display("FAIL %s stall_cycles got %0d want 33", tag, stalls);
            end
            for (int i = 0; i <= mst; i++) begin
                checks++;
                if (Valid !== 1'b1 || EX_ALU_Stall !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_hold[%0d] valid/stall got %b/%b want 1/0", tag, i, Valid, EX_ALU_Stall);
                end
                checks++;
                if (Quotient !== e.q) begin
                    errors++; $display("FAIL %s quotient[%0d] got %h want %h", tag, i, Quotient, e.q);
                end
                checks++;
                if (Remainder !== e.r) begin
                    errors++; $display("FAIL %s remainder[%0d] got %h want %h", tag, i, Remainder, e.r);
                end
                if (i == mst) begin
                    M_Stall = 1'b0; Start = 1'b0;
                end
                @(negedge clk);
                #1;
            end
            checks++;
            if (Valid !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
                errors++;
                $display("FAIL %s back_to_idle valid/stall got %b/%b want 0/0", tag, Valid, EX_ALU_Stall);
            end
            last_q = e.q;
            last_r = e.r;
        end
        $display("op %s %s %h / %h -> q=%h r=%h", tag, sgn ? "DIV" : "DIVU", a, b, Quotient, Remainder);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; M_Stall = 1'b0; Flush = 1'b0;
        Dividend = '0; Divisor = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (Quotient !== 32'd0 || Remainder !== 32'd0 || Valid !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset q/r/valid/stall got %h/%h/%b/%b want 0/0/0/0", Quotient, Remainder, Valid, EX_ALU_Stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset done");
    endtask

    task automatic test_divu_basic();
        run_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    endtask

    task automatic test_signed();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, "div_m7_m2");
    endtask

    task automatic test_boundaries();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
        run_op(1'b0, 32'd5, 32'd0, 0, "divu_by_zero");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, "div_neg_by_zero");
        run_op(1'b1, 32'd5, 32'd0, 0, "div_pos_by_zero");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "divu_max_max");
    endtask

    task automatic test_mstall();
        run_op(1'b0, 32'd1000, 32'd9, 5, "mstall_hold");
    endtask

    task automatic test_flush();
        sb.push_back(model(1'b0, 32'd12345, 32'd11));
        @(negedge clk);
        Start = 1'b1; Signed = 1'b0; Dividend = 32'd12345; Divisor = 32'd11;
        repeat (10) @(negedge clk);
        Flush = 1'b1;
        #1;
        checks++;
        if (EX_ALU_Stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %b want 0", EX_ALU_Stall);
        end
        @(negedge clk);
        Flush = 1'b0; Start = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if (Valid !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
            errors++; $display("FAIL flush_idle valid/stall got %b/%b want 0/0", Valid, EX_ALU_Stall);
        end
        checks++;
        if (Quotient !== last_q || Remainder !== last_r) begin
            errors++; $display("FAIL flush_keep q/r got %h/%h want %h/%h", Quotient, Remainder, last_q, last_r);
        end
        // Flush beats Start in IDLE: nothing may load.
        @(negedge clk);
        Start = 1'b1; Flush = 1'b1;
        #1;
        checks++;
        if (EX_ALU_Stall !== 1'b0) begin
            errors++; $display("FAIL flush_over_start stall got %b want 0", EX_ALU_Stall);
        end
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        #1;
        checks++;
        if (EX_ALU_Stall !== 1'b0 || Valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_load stall/valid got %b/%b want 0/0", EX_ALU_Stall, Valid);
        end
        $display("flush scenario done");
        run_op(1'b0, 32'd9, 32'd3, 0, "after_flush_9_3");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        Start = 1'b1; Signed = 1'b1; Dividend = 32'd777; Divisor = 32'd5;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0; Start = 1'b0;
        #1;
        checks++;
        if (Quotient !== 32'd0 || Remainder !== 32'd0 || Valid !== 1'b0 || EX_ALU_Stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset q/r/valid/stall got %h/%h/%b/%b want 0/0/0/0", Quotient, Remainder, Valid, EX_ALU_Stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_q = '0; last_r = '0;
        $display("async reset scenario done");
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            s = i[0];
            run_op(s, a, b, i % 3, "random");
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundaries();
        test_mstall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
